// File: rtl/bridge_target_cmd.sv
// Core-to-host command mailbox on the bridge bus.
// Optional POSTED-state host-ack timeout: define BRIDGE_TARGET_CMD_TIMEOUT_EN.
module bridge_target_cmd #(
  parameter logic [31:0] BASE_ADDR      = 32'hF800_2000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  bridge_addr,
  input  logic         bridge_wr,
  input  logic [31:0]  bridge_wr_data,
  input  logic         bridge_rd,
  output logic [31:0]  bridge_rd_data,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [15:0]  req_cmd,
  input  logic [255:0] req_param,
  output logic         resp_valid,
  output logic [15:0]  resp_result,
  output logic [255:0] resp_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POSTED,
    S_ACKED,
    S_RESPOND
  } state_t;

  localparam logic [15:0] TAG_POST = 16'h636D;
  localparam logic [15:0] TAG_ACK  = 16'h6361;
  localparam logic [15:0] TAG_DONE = 16'h6464;

  state_t           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      result_q, result_d;
  logic [7:0][31:0] param_q, param_d;
  logic [7:0][31:0] rsp_q, rsp_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      word0;

  logic       hit;
  logic [5:0] widx;
  logic       w0_sel, par_sel, rsp_sel;
  logic       w0_wr, rsp_wr;
  logic [15:0] wr_tag;

  assign hit     = (bridge_addr[31:8] == BASE_ADDR[31:8])
                 && (bridge_addr[1:0] == 2'b00);
  assign widx    = bridge_addr[7:2];
  assign w0_sel  = hit && (widx == 6'd0);
  assign par_sel = hit && (widx[5:3] == 3'b001);
  assign rsp_sel = hit && (widx[5:3] == 3'b010);
  assign w0_wr   = bridge_wr && w0_sel;
  assign rsp_wr  = bridge_wr && rsp_sel;
  assign wr_tag  = bridge_wr_data[31:16];

  always_comb begin
    word0 = 32'h0;
    unique case (state_q)
      S_IDLE:    word0 = 32'h0;
      S_POSTED:  word0 = {TAG_POST, cmd_q};
      S_ACKED:   word0 = {TAG_ACK, cmd_q};
      S_RESPOND: word0 = {TAG_DONE, result_q};
      default:   word0 = 32'h0;
    endcase
  end

  // Reads see pre-write state, so a same-cycle word-0 write is invisible here
  always_comb begin
    rd_data_d = rd_data_q;
    if (bridge_rd) begin
      rd_data_d = 32'h0;
      if (w0_sel)       rd_data_d = word0;
      else if (par_sel) rd_data_d = param_q[widx[2:0]];
      else if (rsp_sel) rd_data_d = rsp_q[widx[2:0]];
    end
  end

`ifdef BRIDGE_TARGET_CMD_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        expired;

  assign expired = (cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 32'h0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  logic expired;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    param_d  = param_q;
    rsp_d    = rsp_q;
`ifdef BRIDGE_TARGET_CMD_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    if ((state_q == S_POSTED || state_q == S_ACKED) && rsp_wr)
      rsp_d[widx[2:0]] = bridge_wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d    = req_cmd;
          param_d  = req_param;
          rsp_d    = '0;
          result_d = 16'h0;
          state_d  = S_POSTED;
`ifdef BRIDGE_TARGET_CMD_TIMEOUT_EN
          cnt_d    = 32'h0;
`endif
        end
      end
      S_POSTED: begin
`ifdef BRIDGE_TARGET_CMD_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
        if (w0_wr && wr_tag == TAG_ACK) begin
          state_d = S_ACKED;
        end else if (w0_wr && wr_tag == TAG_DONE) begin
          result_d = bridge_wr_data[15:0];
          state_d  = S_RESPOND;
        end else if (expired) begin
          result_d = 16'hFFFF;
          rsp_d    = '0;
          state_d  = S_RESPOND;
        end
      end
      S_ACKED: begin
        if (w0_wr && wr_tag == TAG_DONE) begin
          result_d = bridge_wr_data[15:0];
          state_d  = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= 16'h0;
      result_q  <= 16'h0;
      param_q   <= '0;
      rsp_q     <= '0;
      rd_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      result_q  <= result_d;
      param_q   <= param_d;
      rsp_q     <= rsp_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bridge_rd_data = rd_data_q;
  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign resp_valid     = (state_q == S_RESPOND);
  assign resp_result    = result_q;
  assign resp_data      = rsp_q;

endmodule

// File: tb/tb_bridge_target_cmd.sv
// Directed bench for bridge_target_cmd.
// Timeout branch follows BRIDGE_TARGET_CMD_TIMEOUT_EN.
module tb_bridge_target_cmd;

  localparam logic [31:0] BASE = 32'hF800_2000;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  bridge_addr;
  logic         bridge_wr;
  logic [31:0]  bridge_wr_data;
  logic         bridge_rd;
  logic [31:0]  bridge_rd_data;
  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_cmd;
  logic [255:0] req_param;
  logic         resp_valid;
  logic [15:0]  resp_result;
  logic [255:0] resp_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bridge_target_cmd #(
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bridge_addr(bridge_addr),
    .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data),
    .bridge_rd(bridge_rd),
    .bridge_rd_data(bridge_rd_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_param(req_param),
    .resp_valid(resp_valid),
    .resp_result(resp_result),
    .resp_data(resp_data),
    .busy(busy)
  );

  // All bus tasks start and end on a falling edge
  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    bridge_addr    = BASE + {24'h0, off};
    bridge_wr_data = d;
    bridge_wr      = 1'b1;
    @(negedge clk);
    bridge_wr      = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [31:0] d);
    bridge_addr = BASE + {24'h0, off};
    bridge_rd   = 1'b1;
    @(negedge clk);
    bridge_rd   = 1'b0;
    d = bridge_rd_data;
  endtask

  task automatic post(input logic [15:0] c, input logic [255:0] p);
    req_cmd   = c;
    req_param = p;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b want 1/0", req_ready, busy);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 16'h0 || resp_data !== '0) begin
      errors++;
      $display("FAIL reset_resp: v=%b res=%h want 0/0", resp_valid, resp_result);
    end
    checks++;
    if (bridge_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdq: got %h want 0", bridge_rd_data);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_w0: got %h want 0", d);
    end
    bus_rd(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_p0: got %h want 0", d);
    end
  endtask

  task automatic test_full_cmd();
    logic [31:0]  d;
    logic [255:0] p;
    p = '0;
    p[31:0]    = 32'h0000_0003;
    p[255:224] = 32'hA5A5_0007;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    post(16'h0180, p);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_busy: busy=%b ready=%b want 1/0", busy, req_ready);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h636D_0180) begin
      errors++;
      $display("FAIL posted_w0: got %h want 636d0180", d);
    end
    bus_rd(8'h20, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      errors++;
      $display("FAIL param0: got %h want 00000003", d);
    end
    bus_rd(8'h3C, d);
    checks++;
    if (d !== 32'hA5A5_0007) begin
      errors++;
      $display("FAIL param7: got %h want a5a50007", d);
    end
    bus_rd(8'h60, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped: got %h want 0", d);
    end
    bus_wr(8'h00, 32'h1234_0000);
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h636D_0180) begin
      errors++;
      $display("FAIL bad_tag: got %h want 636d0180", d);
    end
    bus_wr(8'h00, 32'h6361_0000);
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h6361_0180) begin
      errors++;
      $display("FAIL acked_w0: got %h want 63610180", d);
    end
    bus_wr(8'h20, 32'hFFFF_FFFF);
    bus_rd(8'h20, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      errors++;
      $display("FAIL param_ro: got %h want 00000003", d);
    end
    bus_wr(8'h40, 32'hDEAD_BEEF);
    bus_wr(8'h5C, 32'h1234_5678);
    bus_rd(8'h40, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rsp0_rd: got %h want deadbeef", d);
    end
    bus_wr(8'h00, 32'h6464_0002);
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0002) begin
      errors++;
      $display("FAIL done_resp: v=%b res=%h want 1/0002", resp_valid, resp_result);
    end
    checks++;
    if (resp_data[31:0] !== 32'hDEAD_BEEF || resp_data[255:224] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL done_data: w0=%h w7=%h want deadbeef/12345678",
               resp_data[31:0], resp_data[255:224]);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h6464_0002) begin
      errors++;
      $display("FAIL respond_w0: got %h want 64640002", d);
    end
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== 16'h0002) begin
      errors++;
      $display("FAIL after_resp: v=%b busy=%b res=%h want 0/0/0002",
               resp_valid, busy, resp_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    post(16'h0042, '0);
    req_cmd   = 16'h0099;
    req_param = {8{32'h5555_AAAA}};
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got %b want 0", req_ready);
    end
    bus_wr(8'h00, 32'h6464_0000);
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0 || resp_data !== '0) begin
      errors++;
      $display("FAIL direct_done: v=%b res=%h w0=%h want 1/0/0",
               resp_valid, resp_result, resp_data[31:0]);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL respond_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reaccept: ready=%b v=%b want 1/0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h636D_0099) begin
      errors++;
      $display("FAIL second_cmd: got %h want 636d0099", d);
    end
    bus_rd(8'h24, d);
    checks++;
    if (d !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL second_p1: got %h want 5555aaaa", d);
    end
    bus_wr(8'h00, 32'h6464_0007);
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0007) begin
      errors++;
      $display("FAIL second_done: v=%b res=%h want 1/0007", resp_valid, resp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] d;
    post(16'h0011, '0);
    bridge_addr    = BASE;
    bridge_wr_data = 32'h6361_0000;
    bridge_wr      = 1'b1;
    bridge_rd      = 1'b1;
    @(negedge clk);
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
    checks++;
    if (bridge_rd_data !== 32'h636D_0011) begin
      errors++;
      $display("FAIL rw_pre: got %h want 636d0011", bridge_rd_data);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h6361_0011) begin
      errors++;
      $display("FAIL rw_post: got %h want 63610011", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit          seen;
    seen  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen || busy !== 1'b0 || resp_result !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: seen=%b busy=%b res=%h want 0/0/0",
               seen, busy, resp_result);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_w0: got %h want 0", d);
    end
    bus_wr(8'h40, 32'h1111_2222);
    bus_rd(8'h40, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL idle_rsp_wr: got %h want 0", d);
    end
  endtask

  task automatic test_timeout();
    int n;
    post(16'h0300, '0);
    n = 0;
`ifdef BRIDGE_TARGET_CMD_TIMEOUT_EN
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_lat: got %0d want 16", n);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 16'hFFFF || resp_data !== '0) begin
      errors++;
      $display("FAIL timeout_resp: v=%b res=%h want 1/ffff", resp_valid, resp_result);
    end
    @(negedge clk);
`else
    repeat (1000) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    checks++;
    if (busy !== 1'b1 || n !== 0) begin
      errors++;
      $display("FAIL no_timeout: busy=%b pulses=%0d want 1/0", busy, n);
    end
    bus_wr(8'h00, 32'h6464_0005);
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0005) begin
      errors++;
      $display("FAIL late_done: v=%b res=%h want 1/0005", resp_valid, resp_result);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    reset          = 1'b1;
    bridge_addr    = 32'h0;
    bridge_wr      = 1'b0;
    bridge_wr_data = 32'h0;
    bridge_rd      = 1'b0;
    req_valid      = 1'b0;
    req_cmd        = 16'h0;
    req_param      = '0;
    @(negedge clk);
    test_reset();
    test_full_cmd();
    test_back_to_back();
    test_same_cycle_rw();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bridge_target_cmd.md
Name: bridge_target_cmd

Overview:
- Core-initiated ("target") command mailbox: the core-to-host direction of the bridge command protocol.
- The core posts one command word plus up to 8 parameter words into a bridge-visible register window. The host polls the window, acknowledges, executes the command, writes response words and a done/result word.
- The block returns the result to the core on a single-cycle response strobe.
- Sits beside the host-command handler on the same bridge bus, at a distinct base address.

Parameters:
- BASE_ADDR, 32'hF800_2000, 256-byte-aligned base of the mailbox window; decode uses bridge_addr[31:8].
- TIMEOUT_CYCLES, 32'd74_250_000, cycles to wait for host ack before abort; used only with the optional feature.

Ports:
- clk  in  1  bridge/core clock; all signals synchronous to it.
- reset  in  1  synchronous, active-high reset.
- bridge_addr  in  32  bridge byte address.
- bridge_wr  in  1  bridge write strobe, one cycle per word.
- bridge_wr_data  in  32  bridge write data.
- bridge_rd  in  1  bridge read strobe.
- bridge_rd_data  out  32  read data, valid the cycle after bridge_rd.
- req_valid  in  1  core command request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_cmd  in  16  target command code, e.g. 16'h0180 dataslot read.
- req_param  in  256  8 parameter words; word n = req_param[32n+31:32n].
- resp_valid  out  1  one-cycle pulse, result available.
- resp_result  out  16  host result code (16'hFFFF = timeout).
- resp_data  out  256  8 response words written by host.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock domain; synchronous active-high reset.
- Reset values: state IDLE, cmd/param/response registers 0, bridge_rd_data 0, resp_valid 0, resp_result 0, resp_data 0, busy 0.
- Window map (byte offsets from BASE_ADDR):
  - 0x00 status/command.
  - 0x20–0x3C param words 0–7, host read-only.
  - 0x40–0x5C response words 0–7, host read/write.
  - All other offsets read 0; writes to them are ignored.
- Word 0 read value by state:
  - IDLE: 0.
  - POSTED: {16'h636D, cmd}.
  - ACKED: {16'h6361, cmd}.
  - RESPOND: {16'h6464, result}.
- Read timing: bridge_rd_data is registered, 1-cycle latency, updated only on bridge_rd.
- State IDLE:
  - req_ready=1.
  - On req_valid: latch req_cmd and req_param, clear response words to 0, go to POSTED.
- State POSTED:
  - Host write to 0x00 with data[31:16]==16'h6361 goes to ACKED.
  - Host write with data[31:16]==16'h6464 goes directly to RESPOND, latching result=data[15:0].
  - Any other word-0 write is ignored.
- State ACKED:
  - Word-0 write with upper half 16'h6464 latches result and goes to RESPOND.
  - Other word-0 writes are ignored.
- Response-word writes: accepted only in POSTED/ACKED. In IDLE/RESPOND they are ignored.
- State RESPOND (one cycle):
  - resp_valid=1; resp_result and resp_data driven from latches and held until the next request.
  - Next state IDLE.
- Request acceptance: a new request can be accepted no earlier than the cycle after RESPOND. Back-to-back throughput is therefore bounded by the host.
- req_valid outside IDLE is not accepted (req_ready=0); the core must hold it.
- Reset mid-command: abort to IDLE with no resp_valid; word 0 reads 0 thereafter.
- Same-cycle bridge_rd and bridge_wr to word 0: the read returns the pre-write value.

Optional Feature:
- Macro: BRIDGE_TARGET_CMD_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to POSTED and increments each POSTED cycle.
  - On reaching TIMEOUT_CYCLES without ack, the block goes to RESPOND with result 16'hFFFF and response words 0.
  - ACKED has no timeout.
- Without the macro: no counter; POSTED waits indefinitely.

Test Plan:
- Reset, then read 0x00 and 0x20 → rd_data 0 both; req_ready=1, busy=0.
- req_cmd=16'h0180, param0=32'h0000_0003 → next cycle busy=1. Read 0x00 = 32'h636D_0180; read 0x20 = 32'h0000_0003.
- Continue: host writes 0x00=32'h6361_0000 → reads 32'h6361_0180. Write 0x40=32'hDEAD_BEEF, then 0x00=32'h6464_0002 → resp_valid one cycle, resp_result=16'h0002, resp_data[31:0]=32'hDEAD_BEEF.
- Host writes 0x00=32'h6464_0000 while POSTED (no ack) → resp_valid, result 0. req_valid during busy keeps req_ready=0 until after RESPOND.
- Reset asserted in ACKED → IDLE, no resp_valid, word 0 reads 0. Response write in IDLE is ignored: 0x40 reads 0.
- TIMEOUT_EN with TIMEOUT_CYCLES=16 and no host activity → resp_valid 16 cycles after POSTED entry, result 16'hFFFF. Without the macro, still busy after 1000 cycles.
